// File: rtl/key_event_scheduler.sv
// Detects key-on/key-off edges per channel at the sample-rate enable, holds them as
// pending events, and serves them round-robin to the envelope sequencer over valid/ready.
module key_event_scheduler #(
    parameter int NUM_CH = 18,
    parameter int CH_W   = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clk_en,
    input  logic [NUM_CH-1:0] key_on,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CH_W-1:0]   evt_ch,
    output logic              evt_is_on,
    output logic              evt_drop
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nxt;
    logic [NUM_CH-1:0]   key_r;
    logic [NUM_CH-1:0]   pend_r;
    logic [NUM_CH-1:0]   pend_on_r;
    logic [CH_W-1:0]     rr_ptr_r;
    logic [NUM_CH-1:0]   edge_s;
    logic [NUM_CH-1:0]   grant_mask_s;
    logic [NUM_CH-1:0]   pend_nxt;
    logic [NUM_CH-1:0]   pend_on_nxt;
    logic [CH_W-1:0]     sel_s;
    logic                found_s;
    logic [CH_W-1:0]     rr_nxt;
    logic [CH_W-1:0]     ch_nxt;
    logic                valid_nxt;
    logic                is_on_nxt;
    logic                drop_s;

    // Channel index k steps past base, wrapping at NUM_CH.
    function automatic logic [CH_W-1:0] wrap_idx(input logic [CH_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_CH) begin
            s = s - NUM_CH;
        end else begin
            s = s;
        end
        return s[CH_W-1:0];
    endfunction

    // Edge detection: only meaningful on sample-rate cycles.
    always_comb begin
        edge_s = {NUM_CH{1'b0}};
        if (clk_en) begin
            edge_s = key_on ^ key_r;
        end else begin
            edge_s = {NUM_CH{1'b0}};
        end
    end

    // Round-robin search for the first pending channel at or after rr_ptr.
    always_comb begin
        found_s = 1'b0;
        sel_s   = {CH_W{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            if (!found_s && pend_r[wrap_idx(rr_ptr_r, k)]) begin
                found_s = 1'b1;
                sel_s   = wrap_idx(rr_ptr_r, k);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Arbiter next-state and next-output logic.
    always_comb begin
        state_nxt    = state_r;
        valid_nxt    = evt_valid;
        ch_nxt       = evt_ch;
        is_on_nxt    = evt_is_on;
        rr_nxt       = rr_ptr_r;
        grant_mask_s = {NUM_CH{1'b0}};
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_nxt           = OFFER;
                    valid_nxt           = 1'b1;
                    ch_nxt              = sel_s;
                    is_on_nxt           = pend_on_r[sel_s];
                    grant_mask_s[sel_s] = 1'b1;
                end else begin
                    valid_nxt = 1'b0;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                    rr_nxt    = (evt_ch == CH_W'(NUM_CH - 1)) ? {CH_W{1'b0}}
                                                              : evt_ch + CH_W'(1);
                end else begin
                    state_nxt = OFFER;
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    // A new edge always sets pending (the set beats a same-cycle grant); a drop is an overwrite of an unserved event.
    always_comb begin
        pend_nxt    = (pend_r & ~grant_mask_s) | edge_s;
        pend_on_nxt = (pend_on_r & ~edge_s) | (key_on & edge_s);
        drop_s      = |(edge_s & pend_r & ~grant_mask_s);
    end

    // State, pending bookkeeping and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            key_r     <= {NUM_CH{1'b0}};
            pend_r    <= {NUM_CH{1'b0}};
            pend_on_r <= {NUM_CH{1'b0}};
            rr_ptr_r  <= {CH_W{1'b0}};
            evt_valid <= 1'b0;
            evt_ch    <= {CH_W{1'b0}};
            evt_is_on <= 1'b0;
            evt_drop  <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            if (clk_en) begin
                key_r <= key_on;
            end else begin
                key_r <= key_r;
            end
            pend_r    <= pend_nxt;
            pend_on_r <= pend_on_nxt;
            rr_ptr_r  <= rr_nxt;
            evt_valid <= valid_nxt;
            evt_ch    <= ch_nxt;
            evt_is_on <= is_on_nxt;
            evt_drop  <= drop_s;
        end
    end

endmodule

// File: tb/tb_key_event_scheduler.sv
// Random and directed stimulus for key_event_scheduler; a queue-based reference model
// predicts per-cycle valid/drop and the ordered event stream, checked by a separate monitor.
module tb_key_event_scheduler;

    localparam int NUM_CH = 18;
    localparam int CH_W   = 5;

    logic              clk;
    logic              reset_n;
    logic              clk_en;
    logic [NUM_CH-1:0] key_on;
    logic              evt_valid;
    logic              evt_ready;
    logic [CH_W-1:0]   evt_ch;
    logic              evt_is_on;
    logic              evt_drop;

    key_event_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clk_en    (clk_en),
        .key_on    (key_on),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .evt_is_on (evt_is_on),
        .evt_drop  (evt_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic valid;
        logic drop;
    } cyc_t;

    typedef struct {
        int   ch;
        logic on;
    } evt_t;

    cyc_t cyc_q[$];
    evt_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: per-channel pending flags and a round-robin pointer.
    logic [NUM_CH-1:0] m_key, m_pend, m_pend_on;
    int   m_rr, m_ch;
    logic m_valid;
    logic [NUM_CH-1:0] kv;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_key = '0; m_pend = '0; m_pend_on = '0;
        m_rr = 0; m_ch = 0; m_valid = 1'b0;
    endtask

    // Applies the inputs about to be sampled at the next rising edge to the model.
    task automatic model_step();
        logic [NUM_CH-1:0] edg;
        logic d;
        int j;
        if (!reset_n) begin
            model_reset();
            cyc_q.push_back('{valid: 1'b0, drop: 1'b0});
            return;
        end
        edg = clk_en ? (key_on ^ m_key) : '0;
        j = -1;
        if (!m_valid) begin
            for (int k = 0; k < NUM_CH; k++) begin
                int c = (m_rr + k) % NUM_CH;
                if (m_pend[c]) begin
                    j = c;
                    break;
                end
            end
            if (j >= 0) begin
                exp_q.push_back('{ch: j, on: m_pend_on[j]});
                m_pend[j] = 1'b0;
                m_valid = 1'b1;
                m_ch = j;
            end
        end else if (evt_ready) begin
            m_valid = 1'b0;
            m_rr = (m_ch + 1) % NUM_CH;
        end
        d = |(edg & m_pend);
        m_pend = m_pend | edg;
        m_pend_on = (m_pend_on & ~edg) | (key_on & edg);
        if (clk_en) m_key = key_on;
        cyc_q.push_back('{valid: m_valid, drop: d});
    endtask

    task automatic cyc(input logic en, input logic rdy, input logic rst);
        @(negedge clk);
        key_on = kv; clk_en = en; evt_ready = rdy; reset_n = rst;
        model_step();
    endtask

    task automatic run(input int n, input logic en, input logic rdy);
        for (int i = 0; i < n; i++) cyc(en, rdy, 1'b1);
    endtask

    // Monitor: compares every cycle's valid/drop, and each newly offered event against the queue.
    cyc_t mon_e;
    evt_t mon_x;
    logic prev_valid = 1'b0;
    logic [CH_W-1:0] prev_ch = '0;
    logic prev_on = 1'b0;
    always @(posedge clk) begin
        #1;
        if (cyc_q.size() > 0) begin
            mon_e = cyc_q.pop_front();
            chk("evt_valid", int'(evt_valid), int'(mon_e.valid));
            chk("evt_drop", int'(evt_drop), int'(mon_e.drop));
            if (!reset_n) begin
                chk("reset_evt_ch", int'(evt_ch), 0);
                chk("reset_evt_is_on", int'(evt_is_on), 0);
            end else if (evt_valid === 1'b1 && prev_valid !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event_ch", int'(evt_ch), -1);
                end else begin
                    mon_x = exp_q.pop_front();
                    chk("event_ch", int'(evt_ch), mon_x.ch);
                    chk("event_is_on", int'(evt_is_on), int'(mon_x.on));
                end
            end else if (evt_valid === 1'b1 && prev_valid === 1'b1) begin
                chk("hold_ch", int'(evt_ch), int'(prev_ch));
                chk("hold_is_on", int'(evt_is_on), int'(prev_on));
            end
        end
        prev_valid = evt_valid;
        prev_ch = evt_ch;
        prev_on = evt_is_on;
    end

    initial begin
        reset_n = 1'b0; clk_en = 1'b0; evt_ready = 1'b0; key_on = '0; kv = '0;
        model_reset();
        // Reset, then idle sampling of all-zero keys.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0);
        run(4, 1'b1, 1'b1);
        // Single key-on on channel 3 with ready tied high.
        kv[3] = 1'b1;
        run(1, 1'b1, 1'b1);
        run(5, 1'b0, 1'b1);
        // Channel 5 key-on moves rr_ptr to 6, then both keys release.
        kv[5] = 1'b1;
        run(1, 1'b1, 1'b1);
        run(4, 1'b0, 1'b1);
        kv[3] = 1'b0; kv[5] = 1'b0;
        run(1, 1'b1, 1'b1);
        run(6, 1'b0, 1'b1);
        // Channels 0, 5, 17 together: served 17, 0, 5.
        kv[0] = 1'b1; kv[5] = 1'b1; kv[17] = 1'b1;
        run(1, 1'b1, 1'b1);
        run(8, 1'b0, 1'b1);
        // Ch2 stalled in offer while ch4 rises then falls: one drop, then ch4 key-off.
        kv[2] = 1'b1;
        run(1, 1'b1, 1'b0);
        run(2, 1'b0, 1'b0);
        kv[4] = 1'b1;
        run(1, 1'b1, 1'b0);
        run(2, 1'b0, 1'b0);
        kv[4] = 1'b0;
        run(1, 1'b1, 1'b0);
        run(2, 1'b0, 1'b0);
        run(6, 1'b0, 1'b1);
        // Reset while ch7 is offered; held key re-triggers after reset.
        kv[7] = 1'b1;
        run(1, 1'b1, 1'b0);
        run(3, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        run(2, 1'b0, 1'b1);
        run(1, 1'b1, 1'b1);
        run(14, 1'b0, 1'b1);
        // Load several events, then toggle keys with clk_en low while draining.
        kv = kv ^ 18'h2A5C3;
        run(1, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            kv = kv ^ (18'd1 << $urandom_range(0, NUM_CH - 1));
            run(1, 1'b0, 1'b1);
        end
        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) kv = kv ^ (18'd1 << $urandom_range(0, NUM_CH - 1));
            cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 499) != 0));
        end
        run(80, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        chk("leftover_events", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
